dflop_pipeline: RTL and testbench



---
 rtl/dflop_pipeline.sv | 77 +++++++
 tb/tb_dflop_pipeline.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dflop_pipeline.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit flops with per-stage valid
// bits, collapsing bubbles and ready/valid handshakes on both sides.
module dflop_pipeline #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_nxt;
  logic [DEPTH-1:0]            free;
  logic [DEPTH-1:0]            src_v;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] src_d;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_nxt;
  logic                        accept;

  // A stage may load when any stage at or beyond it is empty, or the sink takes a beat.
  for (genvar i = 0; i < DEPTH; i++) begin : g_free
    assign free[i] = out_ready | ~(&v_q[DEPTH-1:i]);
  end

  assign in_ready = free[0] & ~flush & rst_n;
  assign accept   = in_valid & in_ready;

  assign src_v[0] = accept;
  assign src_d[0] = in_data;
  for (genvar i = 1; i < DEPTH; i++) begin : g_src
    assign src_v[i] = v_q[i-1];
    assign src_d[i] = d_q[i-1];
  end

  // Payload only moves with a valid beat, so bubbles never overwrite held data.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign v_nxt[i] = free[i] ? src_v[i] : v_q[i];
    assign d_nxt[i] = (free[i] & src_v[i]) ? src_d[i] : d_q[i];
  end

  always_comb begin
    cnt_nxt = CW'($countones(v_nxt));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      d_q <= d_nxt;
      if (flush) begin
        v_q   <= '0;
        cnt_q <= '0;
      end else begin
        v_q   <= v_nxt;
        cnt_q <= cnt_nxt;
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = cnt_q;

endmodule

// File: tb/tb_dflop_pipeline.sv
// Bench for dflop_pipeline: directed scenarios plus random traffic, checked against
// a model that tracks each in-flight beat as (payload, stage position).
module tb_dflop_pipeline;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;

  dflop_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  bit warm  = 1'b0;

  // Model: oldest beat first; position DEPTH-1 is the output stage.
  logic [WIDTH-1:0] qd[$];
  int               qp[$];
  logic [WIDTH-1:0] m_last = '0;

  // Beats observed leaving the DUT, with the cycle number they left in.
  logic [WIDTH-1:0] dq[$];
  int               dt[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  function automatic bit m_ready(input logic ordy, input logic fl, input logic rn);
    return rn && !fl && (qd.size() < DEPTH || ordy);
  endfunction

  task automatic model_edge(input logic iv, input logic [WIDTH-1:0] id,
                            input logic ordy, input logic fl, input logic rn);
    logic [WIDTH-1:0] nd[$];
    int               np[$];
    bit               rdy;
    bit               moves;
    if (!rn) begin
      qd.delete(); qp.delete(); m_last = '0;
      return;
    end
    rdy = m_ready(ordy, fl, rn);
    for (int k = 0; k < qd.size(); k++) begin
      // k older beats sit above this one; a hole exists if they don't fill every slot.
      moves = ordy || (k < DEPTH - 1 - qp[k]);
      if (!moves) begin
        nd.push_back(qd[k]); np.push_back(qp[k]);
      end else if (qp[k] != DEPTH - 1) begin
        nd.push_back(qd[k]); np.push_back(qp[k] + 1);
        if (qp[k] + 1 == DEPTH - 1) m_last = qd[k];
      end
    end
    if (iv && rdy) begin
      nd.push_back(id); np.push_back(0);
      if (DEPTH == 1) m_last = id;
    end
    qd = nd; qp = np;
    if (fl) begin
      qd.delete(); qp.delete();
    end
  endtask

  task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                     input logic fl, input logic rn, output logic acc);
    bit ev;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst_n = rn;
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(m_ready(ordy, fl, rn)));
    if (warm) begin
      ev = qp.size() > 0 && qp[0] == DEPTH - 1;
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev || qd.size() == 0) chk("out_data", int'(out_data), int'(m_last));
      chk("count", int'(count), qd.size());
      if (out_valid && ordy) begin
        dq.push_back(out_data); dt.push_back(cyc_n);
      end
    end
    acc = iv & in_ready;
    @(posedge clk);
    model_edge(iv, id, ordy, fl, rn);
    warm = 1'b1;
    cyc_n++;
    #1;
  endtask

  initial begin
    logic acc;
    int   idx;
    int   p0;
    int   stall_pct;

    // Reset held two cycles with a beat offered.
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_count", int'(count), 0);
    cyc(1'($urandom_range(0, 1)), 8'h5A, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_release_acc", int'(acc), int'(in_valid));

    // Streaming at full rate.
    dq.delete(); dt.delete();
    p0 = cyc_n;
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    chk("stream_n", dq.size(), 8);
    if (dq.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("stream_data", int'(dq[i]), i + 1);
      chk("stream_latency", dt[0] - p0, 4);
      chk("stream_rate", dt[7] - dt[0], 7);
    end

    // Backpressure fill, full pass-through, then drain.
    dq.delete(); dt.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 8'(8'hA0 + idx), 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("fill_accepted", idx, 4);
    chk("fill_count", int'(count), 4);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 8'(8'hA0 + idx), 1'b1, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("pass_accepted", idx, 7);
    chk("pass_count", int'(count), 4);
    for (int c = 0; c < 8; c++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    chk("drain_n", dq.size(), 7);
    if (dq.size() == 7)
      for (int i = 0; i < 7; i++) chk("drain_data", int'(dq[i]), 8'hA0 + i);

    // Bubble collapse under stall.
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, acc);
    for (int c = 0; c < 3; c++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    chk("bubble_count", int'(count), 2);
    dq.delete(); dt.delete();
    for (int c = 0; c < 3; c++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    chk("bubble_n", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("bubble_first", int'(dq[0]), 8'h11);
      chk("bubble_second", int'(dq[1]), 8'h22);
      chk("bubble_gap", dt[1] - dt[0], 1);
    end

    // Flush with three beats held.
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'(8'h31 + c), 1'b0, 1'b0, 1'b1, acc);
    chk("pre_flush_count", int'(count), 3);
    cyc(1'b1, 8'h34, 1'b0, 1'b1, 1'b1, acc);
    chk("flush_acc", int'(acc), 0);
    chk("flush_count", int'(count), 0);
    chk("flush_out_valid", int'(out_valid), 0);

    // Reset together with flush while full.
    for (int c = 0; c < 4; c++) cyc(1'b1, 8'(8'h41 + c), 1'b0, 1'b0, 1'b1, acc);
    chk("pre_rst_data", int'(out_data), 8'h41);
    cyc(1'b1, 8'h45, 1'b1, 1'b1, 1'b0, acc);
    chk("rstfl_acc", int'(acc), 0);
    chk("rstfl_count", int'(count), 0);
    chk("rstfl_out_valid", int'(out_valid), 0);
    chk("rstfl_out_data", int'(out_data), 0);

    // Random traffic with varying stall pressure, occasional flush and reset.
    for (int blk = 0; blk < 8; blk++) begin
      stall_pct = (blk % 4) * 30;
      for (int c = 0; c < 60; c++) begin
        cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 99) >= stall_pct),
            1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 99) != 0), acc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
